csr_access_unit: RTL



---
 rtl/csr_access_unit_if.sv | 42 ++++
 rtl/csr_access_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/csr_access_unit_if.sv
// Request, CSR-array and response bundle for the CSR access unit.
// master = the access unit; slave = execute stage, CSR array and result consumer.
interface csr_access_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [4:0]      req_rs1;
  logic [XLEN-1:0] req_rs1_data;
  logic [11:0]     req_addr;
  logic [1:0]      req_priv;

  logic [11:0]     csr_addr;
  logic            csr_re;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_we;
  logic [XLEN-1:0] csr_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;

  modport master (
    input  req_valid, req_funct3, req_rs1, req_rs1_data, req_addr, req_priv,
    output req_ready,
    output csr_addr, csr_re, csr_we, csr_wdata,
    input  csr_rdata,
    output rsp_valid, rsp_rdata, rsp_illegal,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_funct3, req_rs1, req_rs1_data, req_addr, req_priv,
    input  req_ready,
    input  csr_addr, csr_re, csr_we, csr_wdata,
    output csr_rdata,
    input  rsp_valid, rsp_rdata, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer against a synchronous-read CSR array.
// Illegal requests skip the array and answer one cycle after acceptance.
module csr_access_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic                clock,
  input logic                reset_n,
  csr_access_unit_if.master  io_csr
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e          r_state;
  logic            r_req_ready;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_operand;
  logic            r_wr_intent;
  logic [11:0]     r_csr_addr;
  logic            r_csr_re;
  logic            r_csr_we;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_illegal;

  logic            w_req_fire;
  logic            w_wr_intent;
  logic            w_illegal;
  logic [XLEN-1:0] w_operand;
  logic [XLEN-1:0] w_new;

  assign w_req_fire  = io_csr.req_valid & r_req_ready;
  // Set/clear forms with rs1 == x0 (or uimm == 0) are pure reads.
  assign w_wr_intent = (io_csr.req_funct3[1:0] == 2'b01) | (io_csr.req_rs1 != 5'd0);
  assign w_illegal   = (io_csr.req_funct3[1:0] == 2'b00)
                     | (io_csr.req_priv < io_csr.req_addr[9:8])
                     | ((io_csr.req_addr[11:10] == 2'b11) & w_wr_intent);
  assign w_operand   = io_csr.req_funct3[2] ? {{(XLEN-5){1'b0}}, io_csr.req_rs1}
                                            : io_csr.req_rs1_data;

  // Old value only arrives in WRITE, so the write data is formed combinationally there.
  always_comb begin
    w_new = io_csr.csr_rdata;
    case (r_op)
      2'b01:   w_new = r_operand;
      2'b10:   w_new = io_csr.csr_rdata | r_operand;
      2'b11:   w_new = io_csr.csr_rdata & ~r_operand;
      default: w_new = io_csr.csr_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_req_ready   <= 1'b1;
      r_op          <= 2'b00;
      r_operand     <= '0;
      r_wr_intent   <= 1'b0;
      r_csr_addr    <= 12'd0;
      r_csr_re      <= 1'b0;
      r_csr_we      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_illegal <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req_fire) begin
            r_op        <= io_csr.req_funct3[1:0];
            r_operand   <= w_operand;
            r_wr_intent <= w_wr_intent;
            r_req_ready <= 1'b0;
            if (w_illegal) begin
              r_state       <= StResp;
              r_rsp_valid   <= 1'b1;
              r_rsp_illegal <= 1'b1;
              r_rsp_rdata   <= '0;
            end else begin
              r_state    <= StRead;
              r_csr_re   <= 1'b1;
              r_csr_addr <= io_csr.req_addr;
            end
          end
        end
        StRead: begin
          r_csr_re <= 1'b0;
          r_csr_we <= r_wr_intent;
          r_state  <= StWrite;
        end
        StWrite: begin
          r_csr_we      <= 1'b0;
          r_rsp_valid   <= 1'b1;
          r_rsp_rdata   <= io_csr.csr_rdata;
          r_rsp_illegal <= 1'b0;
          r_state       <= StResp;
        end
        StResp: begin
          if (io_csr.rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_req_ready   <= 1'b1;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_csr.req_ready   = r_req_ready;
  assign io_csr.csr_addr    = r_csr_addr;
  assign io_csr.csr_re      = r_csr_re;
  assign io_csr.csr_we      = r_csr_we;
  assign io_csr.csr_wdata   = (r_state == StWrite) ? w_new : '0;
  assign io_csr.rsp_valid   = r_rsp_valid;
  assign io_csr.rsp_rdata   = r_rsp_rdata;
  assign io_csr.rsp_illegal = r_rsp_illegal;

endmodule
